mru_unique_tracker: RTL and testbench
=====================================

Name: mru_unique_tracker

Overview:
- Parametrised successor to the 4-entry unique-value history block.
- Keeps a move-to-front list of the last DEPTH distinct data values.
  - Slot 0 is the most recent value.
  - Valid entries are always pairwise distinct.
- Adds over the previous generation: per-beat input qualification, flush, hit/miss reporting with hit index, and occupancy.
- Sits downstream of any data stream needing recent-unique history, e.g. ID/tag dedup or address history.

Parameters:
- DATA_W, 8, width of each data value.
- DEPTH, 4, number of list slots; legal range 2..64.
- IDX_W, $clog2(DEPTH), width of the slot index; derived, do not override.

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- in_valid_in  input  1  data_in qualifier for this cycle.
- data_in  input  DATA_W  input value.
- flush_in  input  1  invalidate all slots.
- out_data_o  output  DEPTH*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W].
- out_valid_o  output  DEPTH  bit k = slot k valid.
- hit_o  output  1  one-cycle pulse: last applied beat matched a valid slot.
- miss_o  output  1  one-cycle pulse: last applied beat was new.
- hit_idx_o  output  IDX_W  slot index that matched; valid with hit_o, else 0.
- count_o  output  IDX_W+1  number of valid slots, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): all slot data = 0, out_valid_o = 0, hit_o = miss_o = 0, hit_idx_o = 0, count_o = 0, input stage cleared.
- Stage 1: register in_valid_in and data_in into rx_valid/rx_data on every cycle.
- Stage 2 compare, combinational: eq[k] = (rx_data == slot[k]) & valid[k]. At most one eq bit is ever set.
- Stage 2 update, when rx_valid = 1 and flush is not active:
  - Hit at index h: slots 1..h take slot k-1; slot 0 takes rx_data; slots > h unchanged; valid bits unchanged; count unchanged.
  - Hit at h = 0: list unchanged.
  - Miss: every slot k > 0 takes slot k-1, and valid[k] takes valid[k-1]. Slot 0 takes rx_data with valid[0] = 1. The entry in slot DEPTH-1 is discarded. count = min(count+1, DEPTH).
- When rx_valid = 0: list holds, no pulse.
- Latency: a beat presented at cycle N appears in slot 0, with hit_o/miss_o/hit_idx_o, after edge N+2.
- Outputs are registered; no combinational path from any input to any output.
- Invalid slots compare false even if their data equals rx_data. Invalid slot data is don't-care but held.
- flush_in takes effect at the next edge:
  - All valid bits and count go to 0. Slot data holds.
  - A beat in rx at the same edge is discarded: no hit_o, no miss_o.
  - flush_in also clears rx_valid, so a beat presented in the same cycle as flush_in is dropped.
- Back-to-back equal beats: the first is a miss or hit; the following ones are hit at index 0.
- Full list + miss: the oldest entry is evicted; count stays DEPTH.
- Async reset mid-stream: state clears immediately; the first beat after release is a miss with count 1.

Optional Feature:
- Macro: MRU_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o and miss_cnt_o, each 32 bits.
  - Each increments on its pulse and saturates at all-ones.
  - Both cleared by reset and by flush_in.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mru_pkg holds:
  - function clog2_min1 (IDX_W helper, minimum 1);
  - localparam MAX_DEPTH = 64;
  - typedef struct {hit, miss, idx} mru_result_t, used by the top and by the bench scoreboard.
- One sub-module, mru_match_enc: DEPTH eq bits in, any_hit + one-hot-to-binary hit index out.
  - It is reused by the per-slot shift-enable logic, shift_en[k] = |eq[DEPTH-1:k] | ~any_hit.

Test Plan:
- Reset then stream 1,2,1,2,1 (DEPTH=4, contiguous valid):
  - misses on 1 and 2, then hits at idx 1, 1, 1;
  - final slot0..1 = 1,2, valid = 0011, count = 2.
- Stream 1,2,3,4,5:
  - five misses; final slots = 5,4,3,2;
  - value 1 evicted, count stays 4.
  - Then send 3: hit idx 2, slots = 3,5,4,2.
- Stream 7,7,7 with in_valid_in low on the middle beat:
  - miss, then one hit idx 0;
  - only two pulses total.
- Fill 1..4, assert flush_in with a concurrent beat 9:
  - valid = 0000, count = 0, no pulse for 9;
  - next beat 4 is a miss even though slot data still holds 4.
- Drop reset_n_in low asynchronously mid-stream for half a cycle:
  - outputs go to 0 without a clock edge;
  - after release, beat 5 is a miss with count 1.
- DEPTH=8 random stream of 200 beats from value range 0..11:
  - scoreboard model matches every output each cycle;
  - valid slots always unique;
  - with MRU_STATS_EN, hit_cnt + miss_cnt = 200.

Source files
------------

// File: rtl/mru_pkg.sv
// Shared types and helpers for the MRU unique-value tracker.
package mru_pkg;

  localparam int unsigned MAX_DEPTH = 64;
  localparam int unsigned MAX_IDX_W = 6;

  // Result of one applied beat; idx is sized for MAX_DEPTH and narrowed by users.
  typedef struct packed {
    logic                 hit;
    logic                 miss;
    logic [MAX_IDX_W-1:0] idx;
  } mru_result_t;

  // ceil(log2(n)), never less than 1 so a one-bit index always exists.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r++;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mru_unique_tracker_if.sv
// Data/flush inputs and list/result outputs of the MRU tracker.
// MRU_STATS_EN adds the hit_cnt_o / miss_cnt_o statistics outputs.
interface mru_unique_tracker_if
  import mru_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_W  = clog2_min1(DEPTH)
);

  logic                    in_valid_in;
  logic [DATA_W-1:0]       data_in;
  logic                    flush_in;
  logic [DEPTH*DATA_W-1:0] out_data_o;
  logic [DEPTH-1:0]        out_valid_o;
  logic                    hit_o;
  logic                    miss_o;
  logic [IDX_W-1:0]        hit_idx_o;
  logic [IDX_W:0]          count_o;

`ifdef MRU_STATS_EN
  logic [31:0]             hit_cnt_o;
  logic [31:0]             miss_cnt_o;

  modport master (
    output in_valid_in, data_in, flush_in,
    input  out_data_o, out_valid_o, hit_o, miss_o, hit_idx_o, count_o,
    input  hit_cnt_o, miss_cnt_o
  );
  modport slave (
    input  in_valid_in, data_in, flush_in,
    output out_data_o, out_valid_o, hit_o, miss_o, hit_idx_o, count_o,
    output hit_cnt_o, miss_cnt_o
  );
`else
  modport master (
    output in_valid_in, data_in, flush_in,
    input  out_data_o, out_valid_o, hit_o, miss_o, hit_idx_o, count_o
  );
  modport slave (
    input  in_valid_in, data_in, flush_in,
    output out_data_o, out_valid_o, hit_o, miss_o, hit_idx_o, count_o
  );
`endif

endinterface

// File: rtl/mru_match_enc.sv
// Collapses the per-slot match vector into any-hit and a binary hit index.
module mru_match_enc #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [DEPTH-1:0] i_eq,
  output logic             o_any_hit_c,
  output logic [IDX_W-1:0] o_hit_idx_c
);

  assign o_any_hit_c = |i_eq;

  // Valid entries are distinct, so at most one bit is set and OR-encoding is exact.
  always_comb begin
    o_hit_idx_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (i_eq[k]) o_hit_idx_c = o_hit_idx_c | IDX_W'(k);
    end
  end

endmodule

// File: rtl/mru_unique_tracker.sv
// Move-to-front list of the last DEPTH distinct values with hit/miss reporting.
// Define MRU_STATS_EN to add saturating 32-bit hit/miss counters.
module mru_unique_tracker
  import mru_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_W  = clog2_min1(DEPTH)
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  mru_unique_tracker_if.slave mru_if
);

  localparam int unsigned       CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic                         r_rx_valid;
  logic [DATA_W-1:0]            r_rx_data;
  logic [DEPTH-1:0][DATA_W-1:0] r_slot;
  logic [DEPTH-1:0]             r_valid;
  logic [CNT_W-1:0]             r_count;
  mru_result_t                  r_res;

  logic [DEPTH-1:0]             w_eq;
  logic [DEPTH-1:1]             w_shift_en;
  logic                         w_any_hit;
  logic [IDX_W-1:0]             w_hit_idx;

  // Input stage; a beat arriving alongside flush is dropped here.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= mru_if.in_valid_in & ~mru_if.flush_in;
      r_rx_data  <= mru_if.data_in;
    end
  end

  always_comb begin
    w_eq = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_eq[k] = r_valid[k] && (r_slot[k] == r_rx_data);
    end
  end

  mru_match_enc #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_match_enc (
    .i_eq        (w_eq),
    .o_any_hit_c (w_any_hit),
    .o_hit_idx_c (w_hit_idx)
  );

  // Slot k shifts down when the hit lies at or beyond k, or on any miss.
  always_comb begin
    w_shift_en = '0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      w_shift_en[k] = (|(w_eq >> k)) | ~w_any_hit;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_slot  <= '0;
      r_valid <= '0;
      r_count <= '0;
      r_res   <= '0;
    end else if (mru_if.flush_in) begin
      r_valid <= '0;
      r_count <= '0;
      r_res   <= '0;
    end else begin
      r_res <= '0;
      if (r_rx_valid) begin
        r_slot[0] <= r_rx_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
          if (w_shift_en[k]) r_slot[k] <= r_slot[k-1];
        end
        if (w_any_hit) begin
          r_res.hit <= 1'b1;
          r_res.idx <= MAX_IDX_W'(w_hit_idx);
        end else begin
          r_res.miss <= 1'b1;
          r_valid    <= {r_valid[DEPTH-2:0], 1'b1};
          if (r_count != FULL) r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign mru_if.out_data_o  = r_slot;
  assign mru_if.out_valid_o = r_valid;
  assign mru_if.hit_o       = r_res.hit;
  assign mru_if.miss_o      = r_res.miss;
  assign mru_if.hit_idx_o   = IDX_W'(r_res.idx);
  assign mru_if.count_o     = r_count;

`ifdef MRU_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counters advance on the same edge that raises the matching pulse.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (mru_if.flush_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_rx_valid) begin
      if (w_any_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!w_any_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign mru_if.hit_cnt_o  = r_hit_cnt;
  assign mru_if.miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_mru_unique_tracker.sv
// Self-checking bench: directed DEPTH=4 scenarios plus a DEPTH=8 random stream
// against a queue-based move-to-front model. Honours MRU_STATS_EN.
module tb_mru_unique_tracker;
  import mru_pkg::*;

  localparam int D8 = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   q[$];

  always #5 clk = ~clk;

  mru_unique_tracker_if #(.DATA_W(8), .DEPTH(4)) if4 ();
  mru_unique_tracker_if #(.DATA_W(8), .DEPTH(8)) if8 ();

  mru_unique_tracker #(.DATA_W(8), .DEPTH(4)) u_dut4 (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .mru_if     (if4)
  );

  mru_unique_tracker #(.DATA_W(8), .DEPTH(8)) u_dut8 (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .mru_if     (if8)
  );

  // Move-to-front reference: front of q is the most recent value.
  function automatic mru_result_t model_apply(input int d);
    mru_result_t r;
    int h;
    r = '0;
    h = -1;
    foreach (q[i]) if (q[i] == d) h = i;
    if (h >= 0) begin
      r.hit = 1'b1;
      r.idx = 6'(h);
      q.delete(h);
    end else begin
      r.miss = 1'b1;
      if (q.size() == D8) q.delete(D8 - 1);
    end
    q.push_front(d);
    return r;
  endfunction

  task automatic apply_reset();
    if4.in_valid_in = 1'b0; if4.flush_in = 1'b0; if4.data_in = '0;
    if8.in_valid_in = 1'b0; if8.flush_in = 1'b0; if8.data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step4(input logic v, input logic [7:0] d, input logic f);
    if4.in_valid_in = v; if4.data_in = d; if4.flush_in = f;
    @(posedge clk); #1;
    if4.in_valid_in = 1'b0; if4.flush_in = 1'b0;
  endtask

  task automatic step8(input logic v, input logic [7:0] d);
    if8.in_valid_in = v; if8.data_in = d; if8.flush_in = 1'b0;
    @(posedge clk); #1;
    if8.in_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (if4.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", if4.count_o); end
    n_tests++;
    if (if4.out_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", if4.out_valid_o); end
    n_tests++;
    if (if4.hit_o !== 1'b0 || if4.miss_o !== 1'b0 || if4.hit_idx_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_pulse got hit=%b miss=%b idx=%0d want 0 0 0", if4.hit_o, if4.miss_o, if4.hit_idx_o);
    end
    n_tests++;
    if (if4.out_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", if4.out_data_o); end
    n_tests++;
    if (if8.count_o !== 4'd0 || if8.out_valid_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_d8 got count=%0d valid=%b want 0", if8.count_o, if8.out_valid_o);
    end
    apply_reset();
  endtask

  task automatic test_repeat_pair();
    int seq[6] = '{1, 2, 1, 2, 1, 0};
    int ek[6]  = '{0, 1, 1, 2, 2, 2};
    int ei[6]  = '{0, 0, 0, 1, 1, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step4(i < 5, 8'(seq[i]), 1'b0);
      n_tests++;
      if (if4.hit_o !== (ek[i] == 2) || if4.miss_o !== (ek[i] == 1) || if4.hit_idx_o !== 2'(ei[i])) begin
        n_fail++;
        $display("FAIL repeat_pulse step %0d got hit=%b miss=%b idx=%0d want kind=%0d idx=%0d",
                 i, if4.hit_o, if4.miss_o, if4.hit_idx_o, ek[i], ei[i]);
      end
    end
    n_tests++;
    if (if4.out_data_o[15:0] !== 16'h0201 || if4.out_valid_o !== 4'b0011 || if4.count_o !== 3'd2) begin
      n_fail++;
      $display("FAIL repeat_final got data=%h valid=%b count=%0d want 0201 0011 2",
               if4.out_data_o[15:0], if4.out_valid_o, if4.count_o);
    end
  endtask

  task automatic test_evict();
    int seq[6] = '{1, 2, 3, 4, 5, 0};
    int ek[6]  = '{0, 1, 1, 1, 1, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step4(i < 5, 8'(seq[i]), 1'b0);
      n_tests++;
      if (if4.hit_o !== (ek[i] == 2) || if4.miss_o !== (ek[i] == 1)) begin
        n_fail++;
        $display("FAIL evict_pulse step %0d got hit=%b miss=%b want kind=%0d", i, if4.hit_o, if4.miss_o, ek[i]);
      end
    end
    n_tests++;
    if (if4.out_data_o !== 32'h02030405 || if4.out_valid_o !== 4'b1111 || if4.count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL evict_full got data=%h valid=%b count=%0d want 02030405 1111 4",
               if4.out_data_o, if4.out_valid_o, if4.count_o);
    end
    step4(1'b1, 8'd3, 1'b0);
    step4(1'b0, 8'd0, 1'b0);
    n_tests++;
    if (if4.hit_o !== 1'b1 || if4.miss_o !== 1'b0 || if4.hit_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL evict_hit3 got hit=%b miss=%b idx=%0d want 1 0 2", if4.hit_o, if4.miss_o, if4.hit_idx_o);
    end
    n_tests++;
    if (if4.out_data_o !== 32'h02040503 || if4.count_o !== 3'd4) begin
      n_fail++; $display("FAIL evict_mtf got data=%h count=%0d want 02040503 4", if4.out_data_o, if4.count_o);
    end
  endtask

  task automatic test_back_to_back();
    logic vs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   ek[4] = '{0, 1, 0, 2};
    int   pulses = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step4(vs[i], 8'd7, 1'b0);
      pulses += int'(if4.hit_o) + int'(if4.miss_o);
      n_tests++;
      if (if4.hit_o !== (ek[i] == 2) || if4.miss_o !== (ek[i] == 1) || if4.hit_idx_o !== 2'd0) begin
        n_fail++;
        $display("FAIL b2b_pulse step %0d got hit=%b miss=%b idx=%0d want kind=%0d idx=0",
                 i, if4.hit_o, if4.miss_o, if4.hit_idx_o, ek[i]);
      end
    end
    n_tests++;
    if (pulses != 2 || if4.count_o !== 3'd1) begin
      n_fail++; $display("FAIL b2b_total got pulses=%0d count=%0d want 2 1", pulses, if4.count_o);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 1; i <= 4; i++) step4(1'b1, 8'(i), 1'b0);
    step4(1'b0, 8'd0, 1'b0);
    step4(1'b1, 8'd9, 1'b1);
    n_tests++;
    if (if4.out_valid_o !== 4'b0000 || if4.count_o !== 3'd0 || if4.hit_o !== 1'b0 || if4.miss_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear got valid=%b count=%0d hit=%b miss=%b want 0000 0 0 0",
               if4.out_valid_o, if4.count_o, if4.hit_o, if4.miss_o);
    end
`ifdef MRU_STATS_EN
    n_tests++;
    if (if4.hit_cnt_o !== 32'd0 || if4.miss_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL flush_stats got hit_cnt=%0d miss_cnt=%0d want 0 0", if4.hit_cnt_o, if4.miss_cnt_o);
    end
`endif
    step4(1'b0, 8'd0, 1'b0);
    n_tests++;
    if (if4.hit_o !== 1'b0 || if4.miss_o !== 1'b0 || if4.count_o !== 3'd0 || if4.out_data_o !== 32'h01020304) begin
      n_fail++;
      $display("FAIL flush_drop got hit=%b miss=%b count=%0d data=%h want 0 0 0 01020304",
               if4.hit_o, if4.miss_o, if4.count_o, if4.out_data_o);
    end
    step4(1'b1, 8'd4, 1'b0);
    step4(1'b0, 8'd0, 1'b0);
    n_tests++;
    if (if4.miss_o !== 1'b1 || if4.hit_o !== 1'b0 || if4.count_o !== 3'd1 || if4.out_valid_o !== 4'b0001
        || if4.out_data_o[7:0] !== 8'd4) begin
      n_fail++;
      $display("FAIL flush_refill got hit=%b miss=%b count=%0d valid=%b slot0=%0d want 0 1 1 0001 4",
               if4.hit_o, if4.miss_o, if4.count_o, if4.out_valid_o, if4.out_data_o[7:0]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step4(1'b1, 8'd1, 1'b0);
    step4(1'b1, 8'd2, 1'b0);
    step4(1'b1, 8'd3, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (if4.count_o !== 3'd0 || if4.out_valid_o !== 4'b0000 || if4.miss_o !== 1'b0
        || if4.hit_o !== 1'b0 || if4.out_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_clear got count=%0d valid=%b hit=%b miss=%b data=%h want all 0",
               if4.count_o, if4.out_valid_o, if4.hit_o, if4.miss_o, if4.out_data_o);
    end
    #3 rst_n = 1'b1;
    step4(1'b0, 8'd0, 1'b0);
    n_tests++;
    if (if4.hit_o !== 1'b0 || if4.miss_o !== 1'b0 || if4.count_o !== 3'd0) begin
      n_fail++; $display("FAIL async_drop got hit=%b miss=%b count=%0d want 0 0 0", if4.hit_o, if4.miss_o, if4.count_o);
    end
    step4(1'b1, 8'd5, 1'b0);
    step4(1'b0, 8'd0, 1'b0);
    n_tests++;
    if (if4.miss_o !== 1'b1 || if4.count_o !== 3'd1 || if4.out_data_o[7:0] !== 8'd5) begin
      n_fail++;
      $display("FAIL async_first got miss=%b count=%0d slot0=%0d want 1 1 5", if4.miss_o, if4.count_o, if4.out_data_o[7:0]);
    end
  endtask

  task automatic test_random_d8();
    mru_result_t exp;
    int   sent = 0;
    int   hits = 0;
    int   misses = 0;
    logic pv = 1'b0;
    logic [7:0] pd = '0;
    logic v;
    logic [7:0] d;
    logic dup;
    logic [7:0] exp_valid;
    apply_reset();
    q.delete();
    while (sent < 200 || pv) begin
      v = (sent < 200) && ($urandom_range(0, 9) != 0);
      d = 8'($urandom_range(0, 11));
      if (v) sent++;
      step8(v, d);
      exp = pv ? model_apply(int'(pd)) : '0;
      if (exp.hit) hits++;
      if (exp.miss) misses++;
      n_tests++;
      if (if8.hit_o !== exp.hit || if8.miss_o !== exp.miss || if8.hit_idx_o !== 3'(exp.idx)) begin
        n_fail++;
        $display("FAIL rand_pulse beat %0d got hit=%b miss=%b idx=%0d want %b %b %0d",
                 sent, if8.hit_o, if8.miss_o, if8.hit_idx_o, exp.hit, exp.miss, exp.idx);
      end
      exp_valid = 8'((64'd1 << q.size()) - 64'd1);
      n_tests++;
      if (if8.count_o !== 4'(q.size()) || if8.out_valid_o !== exp_valid) begin
        n_fail++;
        $display("FAIL rand_occ beat %0d got count=%0d valid=%b want %0d %b",
                 sent, if8.count_o, if8.out_valid_o, q.size(), exp_valid);
      end
      foreach (q[i]) begin
        n_tests++;
        if (if8.out_data_o[i*8 +: 8] !== 8'(q[i])) begin
          n_fail++;
          $display("FAIL rand_slot%0d beat %0d got %0d want %0d", i, sent, if8.out_data_o[i*8 +: 8], q[i]);
        end
      end
      dup = 1'b0;
      for (int i = 0; i < D8; i++)
        for (int j = i + 1; j < D8; j++)
          if (if8.out_valid_o[i] && if8.out_valid_o[j] && if8.out_data_o[i*8 +: 8] == if8.out_data_o[j*8 +: 8])
            dup = 1'b1;
      n_tests++;
      if (dup !== 1'b0) begin n_fail++; $display("FAIL rand_unique beat %0d got duplicate want none", sent); end
      pv = v;
      pd = d;
    end
`ifdef MRU_STATS_EN
    n_tests++;
    if (if8.hit_cnt_o + if8.miss_cnt_o !== 32'd200 || if8.hit_cnt_o !== 32'(hits) || if8.miss_cnt_o !== 32'(misses)) begin
      n_fail++;
      $display("FAIL rand_stats got hit_cnt=%0d miss_cnt=%0d want %0d %0d", if8.hit_cnt_o, if8.miss_cnt_o, hits, misses);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    if4.in_valid_in = 1'b0; if4.flush_in = 1'b0; if4.data_in = '0;
    if8.in_valid_in = 1'b0; if8.flush_in = 1'b0; if8.data_in = '0;
    test_reset();
    test_repeat_pair();
    test_evict();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random_d8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
